controle_sequencia_jogo: RTL and testbench

Moore control unit for the sequence-memory game datapath: replays the stored sequence on the LEDs one entry at a time, then waits for and checks the player's moves. The round limit grows by one after each correct round. It drives the datapath's edge-address counter (E), limit counter (L), move register (R), move timeout timer (T) and a new LED-display timer (TM). It replaces the current play-only control unit in the top level; the datapath and hexa7seg debug displays are unchanged.

---
 rtl/jogo_pkg.sv | 59 +++++
 rtl/controle_sequencia_jogo_if.sv | 46 ++++
 rtl/controle_sequencia_jogo.sv | 115 +++++++++++
 tb/tb_controle_sequencia_jogo.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/jogo_pkg.sv
// State codes and control-word layout shared by the sequence-game control unit
// and anything that decodes its db_estado output.
package jogo_pkg;

  localparam logic [3:0] EST_INICIAL        = 4'h0;
  localparam logic [3:0] EST_PREPARA        = 4'h1;
  localparam logic [3:0] EST_MOSTRA         = 4'h2;
  localparam logic [3:0] EST_INTERVALO      = 4'h3;
  localparam logic [3:0] EST_PROX_MOSTRA    = 4'h4;
  localparam logic [3:0] EST_INICIA_JOGADAS = 4'h5;
  localparam logic [3:0] EST_ESPERA         = 4'h6;
  localparam logic [3:0] EST_REGISTRA       = 4'h7;
  localparam logic [3:0] EST_COMPARA        = 4'h8;
  localparam logic [3:0] EST_FIM_RODADA     = 4'h9;
  localparam logic [3:0] EST_PROX_JOGADA    = 4'hA;
  localparam logic [3:0] EST_PROX_RODADA    = 4'hB;
  localparam logic [3:0] EST_FIM_ACERTO     = 4'hC;
  localparam logic [3:0] EST_FIM_TIMEOUT    = 4'hD;
  localparam logic [3:0] EST_FIM_ERRO       = 4'hE;
  localparam logic [3:0] EST_NAO_USADO      = 4'hF;

  typedef enum logic [3:0] {
    INICIAL        = EST_INICIAL,
    PREPARA        = EST_PREPARA,
    MOSTRA         = EST_MOSTRA,
    INTERVALO      = EST_INTERVALO,
    PROX_MOSTRA    = EST_PROX_MOSTRA,
    INICIA_JOGADAS = EST_INICIA_JOGADAS,
    ESPERA         = EST_ESPERA,
    REGISTRA       = EST_REGISTRA,
    COMPARA        = EST_COMPARA,
    FIM_RODADA     = EST_FIM_RODADA,
    PROX_JOGADA    = EST_PROX_JOGADA,
    PROX_RODADA    = EST_PROX_RODADA,
    FIM_ACERTO     = EST_FIM_ACERTO,
    FIM_TIMEOUT    = EST_FIM_TIMEOUT,
    FIM_ERRO       = EST_FIM_ERRO,
    NAO_USADO      = EST_NAO_USADO
  } estado_t;

  typedef struct packed {
    logic zeraE;
    logic contaE;
    logic zeraL;
    logic contaL;
    logic zeraR;
    logic registraR;
    logic zeraT;
    logic contaT;
    logic zeraTM;
    logic contaTM;
    logic ativa_leds;
    logic acertou;
    logic errou;
    logic pronto;
    logic db_timeout;
  } controle_t;

endpackage

// File: rtl/controle_sequencia_jogo_if.sv
// Status/control bundle between the game control unit (master) and the
// datapath (slave).
interface controle_sequencia_jogo_if;

  logic       iniciar;
  logic       jogada;
  logic       timeout;
  logic       botoesIgualMemoria;
  logic       enderecoIgualLimite;
  logic       fimL;
  logic       fimTM;

  logic       zeraE;
  logic       contaE;
  logic       zeraL;
  logic       contaL;
  logic       zeraR;
  logic       registraR;
  logic       zeraT;
  logic       contaT;
  logic       zeraTM;
  logic       contaTM;
  logic       ativa_leds;
  logic       acertou;
  logic       errou;
  logic       pronto;
  logic       db_timeout;
  logic [3:0] db_estado;

  modport master (
    input  iniciar, jogada, timeout, botoesIgualMemoria, enderecoIgualLimite,
           fimL, fimTM,
    output zeraE, contaE, zeraL, contaL, zeraR, registraR, zeraT, contaT,
           zeraTM, contaTM, ativa_leds, acertou, errou, pronto, db_timeout,
           db_estado
  );

  modport slave (
    output iniciar, jogada, timeout, botoesIgualMemoria, enderecoIgualLimite,
           fimL, fimTM,
    input  zeraE, contaE, zeraL, contaL, zeraR, registraR, zeraT, contaT,
           zeraTM, contaTM, ativa_leds, acertou, errou, pronto, db_timeout,
           db_estado
  );

endinterface

// File: rtl/controle_sequencia_jogo.sv
// Moore control unit for the sequence-memory game: replays the stored sequence
// on the LEDs, then collects and checks the player's moves round by round.
module controle_sequencia_jogo
  import jogo_pkg::*;
(
  input  logic                        clock,
  input  logic                        reset,
  controle_sequencia_jogo_if.master   bus
);

  estado_t   estado;
  controle_t ctrl;

  // NOTE: state is updated with non-blocking assignments so every reader sees
  // the pre-edge value; reset is synchronous and overrides every transition.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= INICIAL;
    end else begin
      case (estado)
        INICIAL:        if (bus.iniciar) estado <= PREPARA;
        PREPARA:        estado <= MOSTRA;
        MOSTRA:         if (bus.fimTM) estado <= INTERVALO;
        INTERVALO:      estado <= bus.enderecoIgualLimite ? INICIA_JOGADAS : PROX_MOSTRA;
        PROX_MOSTRA:    estado <= MOSTRA;
        INICIA_JOGADAS: estado <= ESPERA;
        // timeout takes priority over a move seen in the same cycle
        ESPERA: begin
          if (bus.timeout)     estado <= FIM_TIMEOUT;
          else if (bus.jogada) estado <= REGISTRA;
        end
        REGISTRA:       estado <= COMPARA;
        COMPARA: begin
          if (!bus.botoesIgualMemoria)     estado <= FIM_ERRO;
          else if (bus.enderecoIgualLimite) estado <= FIM_RODADA;
          else                              estado <= PROX_JOGADA;
        end
        PROX_JOGADA:    estado <= ESPERA;
        FIM_RODADA:     estado <= bus.fimL ? FIM_ACERTO : PROX_RODADA;
        PROX_RODADA:    estado <= MOSTRA;
        // a restart from a final state skips INICIAL so a held iniciar fires once
        FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: if (bus.iniciar) estado <= PREPARA;
        default:        estado <= INICIAL;
      endcase
    end
  end

  // NOTE: ctrl gets a full default before the case so no latch is inferred.
  always_comb begin
    ctrl = '0;
    case (estado)
      PREPARA: begin
        ctrl.zeraE  = 1'b1;
        ctrl.zeraL  = 1'b1;
        ctrl.zeraR  = 1'b1;
        ctrl.zeraT  = 1'b1;
        ctrl.zeraTM = 1'b1;
      end
      MOSTRA: begin
        ctrl.ativa_leds = 1'b1;
        ctrl.contaTM    = 1'b1;
      end
      INTERVALO:   ctrl.zeraTM = 1'b1;
      PROX_MOSTRA: ctrl.contaE = 1'b1;
      INICIA_JOGADAS: begin
        ctrl.zeraE = 1'b1;
        ctrl.zeraR = 1'b1;
        ctrl.zeraT = 1'b1;
      end
      ESPERA:      ctrl.contaT    = 1'b1;
      REGISTRA:    ctrl.registraR = 1'b1;
      PROX_JOGADA: begin
        ctrl.contaE = 1'b1;
        ctrl.zeraT  = 1'b1;
      end
      PROX_RODADA: begin
        ctrl.contaL = 1'b1;
        ctrl.zeraE  = 1'b1;
        ctrl.zeraTM = 1'b1;
      end
      FIM_ACERTO: begin
        ctrl.acertou = 1'b1;
        ctrl.pronto  = 1'b1;
      end
      FIM_ERRO: begin
        ctrl.errou  = 1'b1;
        ctrl.pronto = 1'b1;
      end
      FIM_TIMEOUT: begin
        ctrl.errou      = 1'b1;
        ctrl.pronto     = 1'b1;
        ctrl.db_timeout = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  assign bus.zeraE      = ctrl.zeraE;
  assign bus.contaE     = ctrl.contaE;
  assign bus.zeraL      = ctrl.zeraL;
  assign bus.contaL     = ctrl.contaL;
  assign bus.zeraR      = ctrl.zeraR;
  assign bus.registraR  = ctrl.registraR;
  assign bus.zeraT      = ctrl.zeraT;
  assign bus.contaT     = ctrl.contaT;
  assign bus.zeraTM     = ctrl.zeraTM;
  assign bus.contaTM    = ctrl.contaTM;
  assign bus.ativa_leds = ctrl.ativa_leds;
  assign bus.acertou    = ctrl.acertou;
  assign bus.errou      = ctrl.errou;
  assign bus.pronto     = ctrl.pronto;
  assign bus.db_timeout = ctrl.db_timeout;
  assign bus.db_estado  = estado;

endmodule

// File: tb/tb_controle_sequencia_jogo.sv
// Directed bench for the game control unit: a driver queues the expected state
// and outputs per cycle, a monitor compares them one cycle later.
module tb_controle_sequencia_jogo;
  import jogo_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  controle_sequencia_jogo_if bus ();

  controle_sequencia_jogo dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // stimulus masks: {reset, iniciar, jogada, timeout, botoes, endIgual, fimL, fimTM}
  localparam logic [7:0] IN_R  = 8'h80;
  localparam logic [7:0] IN_I  = 8'h40;
  localparam logic [7:0] IN_J  = 8'h20;
  localparam logic [7:0] IN_T  = 8'h10;
  localparam logic [7:0] IN_B  = 8'h08;
  localparam logic [7:0] IN_EQ = 8'h04;
  localparam logic [7:0] IN_FL = 8'h02;
  localparam logic [7:0] IN_FT = 8'h01;

  // expected output bits, same order as observed()
  localparam logic [14:0] ZE  = 15'h4000;
  localparam logic [14:0] CE  = 15'h2000;
  localparam logic [14:0] ZL  = 15'h1000;
  localparam logic [14:0] CL  = 15'h0800;
  localparam logic [14:0] ZR  = 15'h0400;
  localparam logic [14:0] RR  = 15'h0200;
  localparam logic [14:0] ZT  = 15'h0100;
  localparam logic [14:0] CT  = 15'h0080;
  localparam logic [14:0] ZTM = 15'h0040;
  localparam logic [14:0] CTM = 15'h0020;
  localparam logic [14:0] AL  = 15'h0010;
  localparam logic [14:0] AC  = 15'h0008;
  localparam logic [14:0] ER  = 15'h0004;
  localparam logic [14:0] PR  = 15'h0002;
  localparam logic [14:0] DT  = 15'h0001;

  typedef struct {
    logic [3:0]  estado;
    logic [14:0] saidas;
    int          id;
  } esperado_t;

  esperado_t fila[$];
  int compared   = 0;
  int mismatched = 0;
  int n_step     = 0;

  function automatic logic [14:0] saidas_spec(input logic [3:0] e);
    case (e)
      EST_PREPARA:        return ZE | ZL | ZR | ZT | ZTM;
      EST_MOSTRA:         return AL | CTM;
      EST_INTERVALO:      return ZTM;
      EST_PROX_MOSTRA:    return CE;
      EST_INICIA_JOGADAS: return ZE | ZR | ZT;
      EST_ESPERA:         return CT;
      EST_REGISTRA:       return RR;
      EST_PROX_JOGADA:    return CE | ZT;
      EST_PROX_RODADA:    return CL | ZE | ZTM;
      EST_FIM_ACERTO:     return AC | PR;
      EST_FIM_ERRO:       return ER | PR;
      EST_FIM_TIMEOUT:    return ER | PR | DT;
      default:            return 15'h0000;
    endcase
  endfunction

  function automatic logic [14:0] observed();
    return {bus.zeraE, bus.contaE, bus.zeraL, bus.contaL, bus.zeraR,
            bus.registraR, bus.zeraT, bus.contaT, bus.zeraTM, bus.contaTM,
            bus.ativa_leds, bus.acertou, bus.errou, bus.pronto, bus.db_timeout};
  endfunction

  // Drive one cycle of inputs and queue the state expected after the next edge.
  task automatic step(input logic [7:0] v, input logic [3:0] exp);
    esperado_t x;
    @(negedge clock);
    reset                   = v[7];
    bus.iniciar             = v[6];
    bus.jogada              = v[5];
    bus.timeout             = v[4];
    bus.botoesIgualMemoria  = v[3];
    bus.enderecoIgualLimite = v[2];
    bus.fimL                = v[1];
    bus.fimTM               = v[0];
    x.estado = exp;
    x.saidas = saidas_spec(exp);
    x.id     = n_step;
    fila.push_back(x);
    n_step++;
  endtask

  initial begin : monitor
    esperado_t e;
    forever begin
      @(posedge clock);
      #1;
      if (fila.size() > 0) begin
        e = fila.pop_front();
        compared++;
        if (bus.db_estado !== e.estado) begin
          mismatched++;
          $display("FAIL step%0d db_estado got %h expected %h", e.id, bus.db_estado, e.estado);
        end
        compared++;
        if (observed() !== e.saidas) begin
          mismatched++;
          $display("FAIL step%0d outputs(state %h) got %b expected %b",
                   e.id, e.estado, observed(), e.saidas);
        end
      end
    end
  end

  initial begin : driver
    reset = 1'b1;
    bus.iniciar = 1'b0; bus.jogada = 1'b0; bus.timeout = 1'b0;
    bus.botoesIgualMemoria = 1'b0; bus.enderecoIgualLimite = 1'b0;
    bus.fimL = 1'b0; bus.fimTM = 1'b0;

    // reset state, then reset while in MOSTRA
    step(IN_R, EST_INICIAL);
    step(8'h00, EST_INICIAL);
    step(IN_J, EST_INICIAL);
    step(IN_I, EST_PREPARA);
    step(8'h00, EST_MOSTRA);
    step(8'h00, EST_MOSTRA);
    step(IN_R | IN_FT, EST_INICIAL);

    // fimTM forced high: 0,1,2,3,5,6
    step(IN_I | IN_FT, EST_PREPARA);
    step(IN_FT, EST_MOSTRA);
    step(IN_FT, EST_INTERVALO);
    step(IN_EQ | IN_FT, EST_INICIA_JOGADAS);
    step(IN_FT, EST_ESPERA);
    step(8'h00, EST_ESPERA);

    // round L = 2: three LED entries, three correct moves, then PROX_RODADA
    step(IN_R, EST_INICIAL);
    step(IN_I, EST_PREPARA);
    step(IN_I | IN_J, EST_MOSTRA);
    step(IN_FT, EST_INTERVALO);
    step(8'h00, EST_PROX_MOSTRA);
    step(IN_J, EST_MOSTRA);
    step(IN_FT, EST_INTERVALO);
    step(8'h00, EST_PROX_MOSTRA);
    step(8'h00, EST_MOSTRA);
    step(IN_FT, EST_INTERVALO);
    step(IN_EQ, EST_INICIA_JOGADAS);
    step(8'h00, EST_ESPERA);
    step(8'h00, EST_ESPERA);
    step(IN_J, EST_REGISTRA);
    step(8'h00, EST_COMPARA);
    step(IN_B, EST_PROX_JOGADA);
    step(8'h00, EST_ESPERA);
    step(IN_J, EST_REGISTRA);
    step(8'h00, EST_COMPARA);
    step(IN_B, EST_PROX_JOGADA);
    step(8'h00, EST_ESPERA);
    step(IN_J, EST_REGISTRA);
    step(8'h00, EST_COMPARA);
    step(IN_B | IN_EQ, EST_FIM_RODADA);
    step(8'h00, EST_PROX_RODADA);
    step(IN_I, EST_MOSTRA);

    // wrong second move
    step(IN_R, EST_INICIAL);
    step(IN_I, EST_PREPARA);
    step(8'h00, EST_MOSTRA);
    step(IN_FT, EST_INTERVALO);
    step(IN_EQ, EST_INICIA_JOGADAS);
    step(8'h00, EST_ESPERA);
    step(IN_J, EST_REGISTRA);
    step(8'h00, EST_COMPARA);
    step(IN_B, EST_PROX_JOGADA);
    step(8'h00, EST_ESPERA);
    step(IN_J, EST_REGISTRA);
    step(8'h00, EST_COMPARA);
    step(IN_EQ, EST_FIM_ERRO);
    step(IN_J, EST_FIM_ERRO);

    // restart from FIM_ERRO, then timeout and jogada together
    step(IN_I, EST_PREPARA);
    step(8'h00, EST_MOSTRA);
    step(IN_FT, EST_INTERVALO);
    step(IN_EQ, EST_INICIA_JOGADAS);
    step(8'h00, EST_ESPERA);
    step(IN_J | IN_T, EST_FIM_TIMEOUT);
    step(8'h00, EST_FIM_TIMEOUT);

    // restart from FIM_TIMEOUT, full game ending in FIM_ACERTO
    step(IN_I, EST_PREPARA);
    step(8'h00, EST_MOSTRA);
    step(IN_FT, EST_INTERVALO);
    step(IN_EQ, EST_INICIA_JOGADAS);
    step(8'h00, EST_ESPERA);
    step(IN_J, EST_REGISTRA);
    step(8'h00, EST_COMPARA);
    step(IN_B | IN_EQ, EST_FIM_RODADA);
    step(IN_FL, EST_FIM_ACERTO);
    step(8'h00, EST_FIM_ACERTO);

    // held iniciar restarts once and never revisits INICIAL
    step(IN_I, EST_PREPARA);
    step(IN_I, EST_MOSTRA);
    step(IN_I, EST_MOSTRA);
    step(8'h00, EST_MOSTRA);

    repeat (3) @(posedge clock);
    #2;
    if (fila.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain pending got %0d expected 0", fila.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
